// File: rtl/piano_pkg.sv
// Shared types and constants for the piano note sequencer.
// FSM encoding plus tone-word and scale-ROM address widths.
package piano_pkg;

    localparam int FCW_WIDTH      = 24;
    localparam int ROM_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOOKUP,
        ST_ECHO,
        ST_PLAY
    } state_e;

endpackage

// File: rtl/piano_note_sequencer_note_length_reg.sv
// Saturating up/down note-length register.
// Sums are formed one bit wider than the register so they never wrap.
module note_length_reg
    import piano_pkg::*;
#(
    parameter int INIT  = 25_000_000,
    parameter int STEP  = 2_500_000,
    parameter int MIN   = 2_500_000,
    parameter int MAX   = 62_500_000,
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] len
);

    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MIN_W  = (WIDTH+1)'(MIN);
    localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] len_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // Next length: clamp the widened sum/difference into [MIN, MAX]
    always_comb begin
        sum   = {1'b0, len_q} + STEP_W;
        diff  = {1'b0, len_q} - STEP_W;
        len_d = len_q;
        if (up && !down) begin
            if (sum > MAX_W) len_d = MAX_W[WIDTH-1:0];
            else             len_d = sum[WIDTH-1:0];
        end else if (down && !up) begin
            if (diff[WIDTH] || diff < MIN_W) len_d = MIN_W[WIDTH-1:0];
            else                             len_d = diff[WIDTH-1:0];
        end
    end

    // Length register, returns to the power-on length on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) len_q <= INIT_W;
        else     len_q <= len_d;
    end

    assign len = len_q;

endmodule

// File: rtl/piano_note_sequencer.sv
// Pops keystrokes from the UART RX FIFO, looks up their tone word,
// echoes them to the TX FIFO and plays the note for len_reg cycles.
module piano_note_sequencer
    import piano_pkg::*;
#(
    parameter int NOTE_LEN_INIT = 25_000_000,
    parameter int LEN_STEP      = 2_500_000,
    parameter int LEN_MIN       = 2_500_000,
    parameter int LEN_MAX       = 62_500_000,
    parameter int LEN_WIDTH     = 26
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                ua_rx_data,
    input  logic                      ua_rx_empty,
    output logic                      ua_rx_rd_en,
    output logic [7:0]                ua_tx_din,
    input  logic                      ua_tx_full,
    output logic                      ua_tx_wr_en,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [FCW_WIDTH-1:0]      rom_data,
    input  logic                      length_up,
    input  logic                      length_down,
    output logic [FCW_WIDTH-1:0]      fcw,
    output logic                      note_en
);

    localparam logic [LEN_WIDTH-1:0] CNT_ONE = LEN_WIDTH'(1);

    state_e                 state_q;
    state_e                 state_d;
    logic [7:0]             char_q;
    logic [7:0]             char_d;
    logic [FCW_WIDTH-1:0]   fcw_q;
    logic [FCW_WIDTH-1:0]   fcw_d;
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic [LEN_WIDTH-1:0]   cnt_d;
    logic [LEN_WIDTH-1:0]   len;
    logic                   echo_go;
    logic                   play_go;

    note_length_reg #(
        .INIT  (NOTE_LEN_INIT),
        .STEP  (LEN_STEP),
        .MIN   (LEN_MIN),
        .MAX   (LEN_MAX),
        .WIDTH (LEN_WIDTH)
    ) u_len (
        .clk  (clk),
        .rst  (rst),
        .up   (length_up),
        .down (length_down),
        .len  (len)
    );

    assign echo_go = (state_q == ST_ECHO) && !ua_tx_full;
    assign play_go = echo_go && (fcw_q != '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: one character at a time, stall in ECHO on TX full
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!ua_rx_empty) state_d = ST_READ;
            ST_READ:   state_d = ST_LOOKUP;
            ST_LOOKUP: state_d = ST_ECHO;
            ST_ECHO: begin
                if (play_go)      state_d = ST_PLAY;
                else if (echo_go) state_d = ST_IDLE;
            end
            ST_PLAY:   if (cnt_q == CNT_ONE) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; length is sampled only when PLAY is entered
    always_comb begin
        char_d = char_q;
        fcw_d  = fcw_q;
        cnt_d  = cnt_q;
        if (state_q == ST_READ)   char_d = ua_rx_data;
        if (state_q == ST_LOOKUP) fcw_d  = rom_data;
        if (play_go)                cnt_d = len;
        else if (state_q == ST_PLAY) cnt_d = cnt_q - CNT_ONE;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_q <= '0;
            fcw_q  <= '0;
            cnt_q  <= '0;
        end else begin
            char_q <= char_d;
            fcw_q  <= fcw_d;
            cnt_q  <= cnt_d;
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        ua_rx_rd_en = (state_q == ST_IDLE) && !ua_rx_empty;
        ua_tx_wr_en = echo_go;
        note_en     = (state_q == ST_PLAY);
        fcw         = note_en ? fcw_q : '0;
        rom_addr    = char_q;
        ua_tx_din   = char_q;
    end

endmodule

// File: tb/tb_piano_note_sequencer.sv
// Directed bench for piano_note_sequencer with short note lengths.
// Models the RX FIFO and the scale ROM; checks every cycle of each note.
module tb_piano_note_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ua_rx_data;
    logic        ua_rx_empty;
    logic        ua_rx_rd_en;
    logic [7:0]  ua_tx_din;
    logic        ua_tx_full;
    logic        ua_tx_wr_en;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic        length_up;
    logic        length_down;
    logic [23:0] fcw;
    logic        note_en;

    int total  = 0;
    int passed = 0;

    logic [7:0] rxq[$];

    piano_note_sequencer #(
        .NOTE_LEN_INIT (8),
        .LEN_STEP      (2),
        .LEN_MIN       (2),
        .LEN_MAX       (12),
        .LEN_WIDTH     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ua_rx_data  (ua_rx_data),
        .ua_rx_empty (ua_rx_empty),
        .ua_rx_rd_en (ua_rx_rd_en),
        .ua_tx_din   (ua_tx_din),
        .ua_tx_full  (ua_tx_full),
        .ua_tx_wr_en (ua_tx_wr_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .length_up   (length_up),
        .length_down (length_down),
        .fcw         (fcw),
        .note_en     (note_en)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom(input logic [7:0] a);
        case (a)
            8'h7A:   return 24'd17979;
            8'h71:   return 24'd35958;
            8'h43:   return 24'd11326;
            default: return 24'd0;
        endcase
    endfunction

    assign rom_data = rom(rom_addr);

    // Expected {rd_en, wr_en, note_en, fcw} at cycle k of one character
    function automatic logic [26:0] exp_vec(input int k, input logic [23:0] f,
                                            input int len, input int s);
        logic rd;
        logic wr;
        logic ne;
        rd = (k == 0);
        wr = (k == 3 + s);
        ne = (f != 0) && (k >= 4 + s) && (k <= 3 + s + len);
        return {rd, wr, ne, (ne ? f : 24'd0)};
    endfunction

    // Advance to the next negedge; serve a pop seen in the cycle just ended
    task automatic tick();
        logic p;
        p = ua_rx_rd_en;
        @(negedge clk);
        if (p && rxq.size() > 0) begin
            ua_rx_data  = rxq.pop_front();
            ua_rx_empty = (rxq.size() == 0);
        end
    endtask

    task automatic pulse(input logic up, input logic dn);
        length_up   = up;
        length_down = dn;
        tick();
        length_up   = 1'b0;
        length_down = 1'b0;
    endtask

    task automatic run_note(input string name, input logic [7:0] ch,
                            input logic [23:0] f, input int len,
                            input int s, input int up_at);
        int last;
        logic [26:0] got;
        logic [26:0] exp;
        last = (f != 0) ? 4 + s + len : 4 + s;
        for (int k = 0; k <= last; k++) begin
            if (k == 0) begin
                rxq.push_back(ch);
                ua_rx_empty = 1'b0;
            end else begin
                tick();
            end
            ua_tx_full = (k >= 3) && (k < 3 + s);
            length_up  = (k == up_at);
            #1;
            got = {ua_rx_rd_en, ua_tx_wr_en, note_en, fcw};
            exp = exp_vec(k, f, len, s);
            total++;
            if (got !== exp)
                $display("FAIL %s c%0d {rd,wr,ne,fcw}: got %h expected %h",
                         name, k, got, exp);
            else passed++;
            if (k == 2) begin
                total++;
                if (rom_addr !== ch)
                    $display("FAIL %s rom_addr: got %h expected %h",
                             name, rom_addr, ch);
                else passed++;
            end
            if (k == 3 + s) begin
                total++;
                if (ua_tx_din !== ch)
                    $display("FAIL %s tx_din: got %h expected %h",
                             name, ua_tx_din, ch);
                else passed++;
            end
        end
        ua_tx_full = 1'b0;
        length_up  = 1'b0;
        tick();
    endtask

    // Two characters queued together; the second pops right after the first
    task automatic run_pair(input string name,
                            input logic [7:0] c1, input logic [23:0] f1,
                            input logic [7:0] c2, input logic [23:0] f2,
                            input int len);
        int o;
        int last;
        logic [26:0] got;
        logic [26:0] exp;
        o    = (f1 != 0) ? 4 + len : 4;
        last = o + ((f2 != 0) ? 4 + len : 4);
        rxq.push_back(c1);
        rxq.push_back(c2);
        ua_rx_empty = 1'b0;
        for (int k = 0; k <= last; k++) begin
            if (k > 0) tick();
            #1;
            got = {ua_rx_rd_en, ua_tx_wr_en, note_en, fcw};
            exp = (k < o) ? exp_vec(k, f1, len, 0) : exp_vec(k - o, f2, len, 0);
            total++;
            if (got !== exp)
                $display("FAIL %s c%0d {rd,wr,ne,fcw}: got %h expected %h",
                         name, k, got, exp);
            else passed++;
            if (k == 3 || k == o + 3) begin
                total++;
                if (ua_tx_din !== ((k == 3) ? c1 : c2))
                    $display("FAIL %s tx_din c%0d: got %h expected %h",
                             name, k, ua_tx_din, (k == 3) ? c1 : c2);
                else passed++;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        ua_rx_data  = 8'h00;
        ua_rx_empty = 1'b1;
        ua_tx_full  = 1'b0;
        length_up   = 1'b0;
        length_down = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({ua_rx_rd_en, ua_tx_wr_en, note_en, fcw, rom_addr, ua_tx_din} !== '0)
            $display("FAIL reset_hold outputs: got %h %h %h %h %h %h expected 0",
                     ua_rx_rd_en, ua_tx_wr_en, note_en, fcw, rom_addr, ua_tx_din);
        else passed++;
        rst = 1'b0;
        tick();
        tick();
        #1;
        total++;
        if ({ua_rx_rd_en, ua_tx_wr_en, note_en, fcw, rom_addr, ua_tx_din} !== '0)
            $display("FAIL reset_idle outputs: got %h %h %h %h %h %h expected 0",
                     ua_rx_rd_en, ua_tx_wr_en, note_en, fcw, rom_addr, ua_tx_din);
        else passed++;
        tick();
    endtask

    task automatic test_play_z();
        run_note("z", 8'h7A, 24'd17979, 8, 0, -1);
    endtask

    task automatic test_no_note();
        run_pair("A_then_q", 8'h41, 24'd0, 8'h71, 24'd35958, 8);
        run_note("hi_char", 8'hC8, 24'd0, 8, 0, -1);
    endtask

    task automatic test_tx_stall();
        run_note("C_stall5", 8'h43, 24'd11326, 8, 5, -1);
    endtask

    task automatic test_back_to_back();
        run_pair("z_q", 8'h7A, 24'd17979, 8'h71, 24'd35958, 8);
    endtask

    task automatic test_length();
        run_note("up_in_play", 8'h7A, 24'd17979, 8, 0, 6);
        run_note("len10", 8'h71, 24'd35958, 10, 0, -1);
        repeat (3) pulse(1'b1, 1'b0);
        run_note("len12_sat", 8'h7A, 24'd17979, 12, 0, -1);
        pulse(1'b1, 1'b1);
        run_note("both_at12", 8'h71, 24'd35958, 12, 0, -1);
        repeat (9) pulse(1'b0, 1'b1);
        run_note("len2_sat", 8'h7A, 24'd17979, 2, 0, -1);
        pulse(1'b1, 1'b1);
        run_note("both_at2", 8'h43, 24'd11326, 2, 0, -1);
    endtask

    task automatic test_reset_in_play();
        logic [26:0] got;
        logic [26:0] exp;
        rxq.push_back(8'h7A);
        ua_rx_empty = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick();
            #1;
            got = {ua_rx_rd_en, ua_tx_wr_en, note_en, fcw};
            exp = exp_vec(k, 24'd17979, 2, 0);
            total++;
            if (got !== exp)
                $display("FAIL rst_play c%0d: got %h expected %h", k, got, exp);
            else passed++;
        end
        rst = 1'b1;
        #1;
        total++;
        if ({ua_rx_rd_en, ua_tx_wr_en, note_en, fcw, rom_addr, ua_tx_din} !== '0)
            $display("FAIL rst_async outputs: got %h %h %h %h %h %h expected 0",
                     ua_rx_rd_en, ua_tx_wr_en, note_en, fcw, rom_addr, ua_tx_din);
        else passed++;
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_note("after_rst_len8", 8'h71, 24'd35958, 8, 0, -1);
    endtask

    initial begin
        test_reset();
        test_play_z();
        test_no_note();
        test_tx_stall();
        test_back_to_back();
        test_length();
        test_reset_in_play();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/piano_note_sequencer.md
# piano_note_sequencer

Turns ASCII keystrokes from the UART receive FIFO into timed notes. For each character it looks up the 24-bit tone word in the external piano scale ROM, echoes the character to the UART transmit FIFO, then plays the note for a programmable number of cycles. It sits between the UART FIFOs, the scale ROM and the NCO/DAC datapath. Its note length is adjusted at runtime by button pulses.

## Interface
- NOTE_LEN_INIT, 25_000_000: note length in clk cycles after reset
- LEN_STEP, 2_500_000: increment/decrement applied per length button pulse
- LEN_MIN, 2_500_000: lower saturation bound of note length
- LEN_MAX, 62_500_000: upper saturation bound of note length
- LEN_WIDTH, 26: width of note length register and play counter
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ua_rx_data  in  8  RX FIFO read data, valid the cycle after ua_rx_rd_en
- ua_rx_empty  in  1  RX FIFO empty
- ua_rx_rd_en  out  1  RX FIFO pop, single-cycle pulse
- ua_tx_din  out  8  echo character
- ua_tx_full  in  1  TX FIFO full
- ua_tx_wr_en  out  1  TX FIFO push, single-cycle pulse
- rom_addr  out  8  scale ROM address (combinational ROM, same-cycle data)
- rom_data  in  24  scale ROM tone word; 0 means no note
- length_up  in  1  single-cycle pulse, already debounced
- length_down  in  1  single-cycle pulse, already debounced
- fcw  out  24  tone word to the NCO; 0 when not playing
- note_en  out  1  high exactly while a note plays

## Operation
- FSM states and transitions:
  - IDLE: if !ua_rx_empty, assert ua_rx_rd_en and go to READ. Otherwise stay.
  - READ: capture ua_rx_data into char_reg, then go to LOOKUP.
  - LOOKUP: rom_addr = char_reg. Latch rom_data into fcw_reg, then go to ECHO.
  - ECHO: wait while ua_tx_full. When not full, assert ua_tx_wr_en with ua_tx_din = char_reg. Then go to PLAY if fcw_reg != 0, else go to IDLE.
  - PLAY: note_en = 1 and fcw = fcw_reg. Load play_cnt = len_reg on entry and decrement each cycle. On the cycle play_cnt == 1, go to IDLE.
- Output defaults:
  - rom_addr = char_reg in every state.
  - fcw = 0 outside PLAY.
  - ua_tx_din holds char_reg at all times.
- Length register (len_reg):
  - length_up alone: len_reg = min(len_reg + LEN_STEP, LEN_MAX).
  - length_down alone: len_reg = max(len_reg − LEN_STEP, LEN_MIN).
  - Both high in the same cycle: no change.
  - Arithmetic is done in LEN_WIDTH+1 bits before clamping, so no wrap-around.
  - Updates are accepted in any state. The length is sampled only on PLAY entry, so a note in progress keeps its length.
- Characters 128–255 address zero ROM rows. They are echoed but not played.
- Back-to-back characters are processed strictly in order, one at a time. No RX pop occurs while in READ/LOOKUP/ECHO/PLAY.
- TX full is handled by stalling in ECHO indefinitely. Characters are never dropped.

## Timing
- Reset values:
  - State = IDLE.
  - ua_rx_rd_en = ua_tx_wr_en = note_en = 0.
  - fcw = 0, char_reg = 0, fcw_reg = 0, play_cnt = 0.
  - len_reg = NOTE_LEN_INIT.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronous). A character already popped is lost.
- Latency with TX not full, counting the cycle where IDLE sees !ua_rx_empty as cycle 0:
  - cycle 0: rd_en
  - cycle 1: capture
  - cycle 2: fcw_reg latch
  - cycle 3: wr_en
  - cycles 4 … 3+len_reg: note_en high
  - cycle 4+len_reg: IDLE, may pop the next character
- ua_tx_full stalls insert whole cycles at ECHO. ua_rx_rd_en and ua_tx_wr_en are never high for more than one consecutive cycle.

## Structure
- Shared package piano_pkg holds:
  - FSM state encoding (IDLE, READ, LOOKUP, ECHO, PLAY)
  - FCW_WIDTH = 24
  - ROM_ADDR_WIDTH = 8
- Sub-module note_length_reg: saturating up/down register with parameters INIT, STEP, MIN, MAX and WIDTH. It is instantiated once.
- The scale ROM stays external and is connected through rom_addr/rom_data.

## Test plan
All scenarios use NOTE_LEN_INIT=8, LEN_STEP=2, LEN_MIN=2, LEN_MAX=12, LEN_WIDTH=4, with the standard scale ROM.
- Push 'z' (0x7A) → rd_en at c0, wr_en with ua_tx_din=0x7A at c3, note_en high c4–c11 with fcw=17979, fcw=0 at c12.
- Push 'A' (0x41, ROM 0) → echo 0x41, note_en never asserts, FSM back to IDLE at c4. Then push 'q' (0x71) → fcw=35958 for 8 cycles.
- Hold ua_tx_full high 5 cycles during ECHO for 'C' (0x43) → wr_en delayed by exactly 5 cycles, then fcw=11326 for 8 cycles.
- Four length_up pulses → len 12 (saturated). length_up during PLAY leaves that note's length unchanged. Nine length_down pulses → len 2. Simultaneous up+down → unchanged.
- Push 'z','q' back-to-back → second rd_en exactly at the cycle after the first note ends, strict order of echoes and notes.
- Assert rst during PLAY → note_en=0 and fcw=0 immediately, len_reg=8, next character processed normally after release.
